// File: rtl/lite_fetch_v1_if.sv
// Fetch/issue bus for lite_fetch_v1: program-load port, start pulse and the
// issue valid/ready handshake. Optional issue_count exists under LITE_FETCH_ISSUE_COUNT_EN.
interface lite_fetch_v1_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 20
);
    logic               load_en;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               start;
    logic               issue_ready;
    logic               issue_valid;
    logic [1:0]         opcode;
    logic [7:0]         d1;
    logic [9:0]         d2;
    logic [ADDR_W-1:0]  pc;
    logic               busy;
    logic               halted;
`ifdef LITE_FETCH_ISSUE_COUNT_EN
    logic [15:0]        issue_count;
`endif

    // Driver side: loads the program and consumes issued instructions
    modport master (
        output load_en, load_addr, load_data, start, issue_ready,
`ifdef LITE_FETCH_ISSUE_COUNT_EN
        input  issue_count,
`endif
        input  issue_valid, opcode, d1, d2, pc, busy, halted
    );

    // Fetch stage side
    modport slave (
        input  load_en, load_addr, load_data, start, issue_ready,
`ifdef LITE_FETCH_ISSUE_COUNT_EN
        output issue_count,
`endif
        output issue_valid, opcode, d1, d2, pc, busy, halted
    );
endinterface

// File: rtl/lite_fetch_v1.sv
// Instruction fetch/issue stage: program RAM, PC stepping, local JUMP/HALT,
// valid/ready issue. Optional handshake counter under LITE_FETCH_ISSUE_COUNT_EN.
module lite_fetch_v1 #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 20
) (
    input  logic            clk,
    input  logic            rst,
    lite_fetch_v1_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             r_state;
    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0]  r_pc;
    logic               r_issue_valid;
    logic [1:0]         r_opcode;
    logic [7:0]         r_d1;
    logic [9:0]         r_d2;
    logic               r_busy;
    logic               r_halted;

    logic [INSTR_W-1:0] w_word;
    logic               w_adv;
    logic               w_start_acc;
    logic               w_handshake;

    assign w_word      = r_mem[r_pc];
    assign w_adv       = !r_issue_valid || bus.issue_ready;
    assign w_start_acc = bus.start && (r_state != S_RUN);
    assign w_handshake = r_issue_valid && bus.issue_ready;

    // Program RAM write port; contents survive rst and are frozen while running
    always_ff @(posedge clk) begin
        if (bus.load_en && (r_state != S_RUN)) begin
            r_mem[bus.load_addr] <= bus.load_data;
        end
    end

    // Control FSM with registered issue outputs and state decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_issue_valid <= 1'b0;
            r_opcode      <= 2'b00;
            r_d1          <= 8'h00;
            r_d2          <= 10'h000;
            r_busy        <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_HALT: begin
                    if (bus.start) begin
                        r_state  <= S_RUN;
                        r_pc     <= '0;
                        r_busy   <= 1'b1;
                        r_halted <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_adv) begin
                        case (w_word[19:18])
                            2'b00, 2'b01: begin
                                r_opcode      <= w_word[19:18];
                                r_d1          <= w_word[17:10];
                                r_d2          <= w_word[9:0];
                                r_issue_valid <= 1'b1;
                                r_pc          <= r_pc + ADDR_W'(1);
                            end
                            2'b10: begin
                                r_pc          <= w_word[ADDR_W-1:0];
                                r_issue_valid <= 1'b0;
                            end
                            default: begin
                                // HALT: pc stays on the HALT word
                                r_state       <= S_HALT;
                                r_issue_valid <= 1'b0;
                                r_busy        <= 1'b0;
                                r_halted      <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_issue_valid <= 1'b0;
                    r_busy        <= 1'b0;
                    r_halted      <= 1'b0;
                end
            endcase
        end
    end

`ifdef LITE_FETCH_ISSUE_COUNT_EN
    logic [15:0] r_issue_count;

    // Saturating count of completed handshakes since the last rst or accepted start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_count <= 16'h0000;
        end else if (w_start_acc) begin
            r_issue_count <= 16'h0000;
        end else if (w_handshake && (r_issue_count != 16'hFFFF)) begin
            r_issue_count <= r_issue_count + 16'h0001;
        end
    end

    assign bus.issue_count = r_issue_count;
`else
    logic w_unused;
    assign w_unused = w_start_acc ^ w_handshake;
`endif

    assign bus.issue_valid = r_issue_valid;
    assign bus.opcode      = r_opcode;
    assign bus.d1          = r_d1;
    assign bus.d2          = r_d2;
    assign bus.pc          = r_pc;
    assign bus.busy        = r_busy;
    assign bus.halted      = r_halted;
endmodule

// File: tb/tb_lite_fetch_v1.sv
// Directed, table-driven bench for lite_fetch_v1 with hand sequences for
// reset-abort, load-while-running, JUMP loop and PC wrap.
module tb_lite_fetch_v1;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    lite_fetch_v1_if #(.ADDR_W(4), .INSTR_W(20)) u_if ();

    lite_fetch_v1 #(.ADDR_W(4), .INSTR_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       start;
        logic       ready;
        logic       v;
        logic       b;
        logic       h;
        logic [1:0] op;
        logic [7:0] d1;
        logic [9:0] d2;
        logic [3:0] pc;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [19:0] mk(input logic [1:0] op, input logic [7:0] a, input logic [9:0] b);
        return {op, a, b};
    endfunction

    function automatic logic [31:0] pack(input logic v, input logic b, input logic h,
                                         input logic [1:0] op, input logic [7:0] a,
                                         input logic [9:0] c, input logic [3:0] p);
        return {5'd0, v, b, h, op, a, c, p};
    endfunction

    function automatic logic [31:0] obs();
        return pack(u_if.issue_valid, u_if.busy, u_if.halted, u_if.opcode, u_if.d1, u_if.d2, u_if.pc);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic r);
        u_if.start       = s;
        u_if.issue_ready = r;
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [19:0] d);
        u_if.load_en   = 1'b1;
        u_if.load_addr = a;
        u_if.load_data = d;
        @(posedge clk);
        #1;
        u_if.load_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int i);
        step(vecs[i].start, vecs[i].ready);
        chk($sformatf("vec%0d", i), obs(),
            pack(vecs[i].v, vecs[i].b, vecs[i].h, vecs[i].op, vecs[i].d1, vecs[i].d2, vecs[i].pc));
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst = 1'b0;
        u_if.load_en = 1'b0;
        u_if.load_addr = 4'd0;
        u_if.load_data = 20'd0;
        u_if.start = 1'b0;
        u_if.issue_ready = 1'b0;

        // Program 1 sequence, then restart from HALT with a 5-cycle stall
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 10'h000, 4'd0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 8'h15, 10'h000, 4'd1};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 10'h3FF, 4'd2};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 10'h3FF, 4'd2};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 10'h3FF, 4'd2};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 10'h3FF, 4'd0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h15, 10'h000, 4'd1};
        for (int i = 7; i < 12; i++)
            vecs[i] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h15, 10'h000, 4'd1};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 8'h00, 10'h3FF, 4'd2};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 10'h3FF, 4'd2};

        rst = 1'b1;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst = 1'b0;
        chk("reset", obs(), pack(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 10'h000, 4'd0));
        step(1'b0, 1'b1);
        chk("idle_hold", obs(), pack(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 10'h000, 4'd0));

        load(4'd0, mk(2'b00, 8'h15, 10'h000));
        load(4'd1, mk(2'b01, 8'h00, 10'h3FF));
        load(4'd2, mk(2'b11, 8'h00, 10'h000));
        for (int i = 0; i < 14; i++) run_vec(i);

        // Reset mid-run with a pending issue, then replay program 1
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("pre_rst_issue", obs(), pack(1'b1, 1'b1, 1'b0, 2'd0, 8'h15, 10'h000, 4'd1));
        do_reset();
        chk("rst_abort", obs(), pack(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 10'h000, 4'd0));
        for (int i = 0; i < 5; i++) run_vec(i);

        // load_en in RUN must be ignored
        step(1'b1, 1'b1);
        u_if.load_en   = 1'b1;
        u_if.load_addr = 4'd0;
        u_if.load_data = mk(2'b11, 8'h00, 10'h000);
        step(1'b0, 1'b1);
        u_if.load_en = 1'b0;
        chk("load_in_run_issue", obs(), pack(1'b1, 1'b1, 1'b0, 2'd0, 8'h15, 10'h000, 4'd1));
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("load_in_run_halt", obs(), pack(1'b0, 1'b0, 1'b1, 2'd1, 8'h00, 10'h3FF, 4'd2));
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("word0_intact", obs(), pack(1'b1, 1'b1, 1'b0, 2'd0, 8'h15, 10'h000, 4'd1));

        // JUMP loop: d1=1 every other cycle, pc alternates 1,0; start in RUN ignored
        do_reset();
        load(4'd0, mk(2'b00, 8'h01, 10'h000));
        load(4'd1, mk(2'b10, 8'h00, 10'h000));
        step(1'b1, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step(k == 3, 1'b1);
            if (k % 2 == 1)
                chk($sformatf("jump_k%0d", k), obs(), pack(1'b1, 1'b1, 1'b0, 2'd0, 8'h01, 10'h000, 4'd1));
            else
                chk($sformatf("jump_k%0d", k), obs(), pack(1'b0, 1'b1, 1'b0, 2'd0, 8'h01, 10'h000, 4'd0));
        end

        // Full RAM, 20 issues with PC wrap
        do_reset();
        for (int a = 0; a < 16; a++) load(4'(a), mk(2'b00, 8'(a), 10'h000));
        step(1'b1, 1'b1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1);
            chk($sformatf("wrap_k%0d", k), obs(),
                pack(1'b1, 1'b1, 1'b0, 2'd0, 8'(k % 16), 10'h000, 4'((k + 1) % 16)));
        end
        step(1'b0, 1'b1);
        chk("wrap_k20", obs(), pack(1'b1, 1'b1, 1'b0, 2'd0, 8'h04, 10'h000, 4'd5));
`ifdef LITE_FETCH_ISSUE_COUNT_EN
        chk("issue_count", {16'd0, u_if.issue_count}, 32'd20);
        do_reset();
        chk("issue_count_rst", {16'd0, u_if.issue_count}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
